// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: arbitrates one unified single-port RAM between the
// instruction-fetch port and the MEM-stage data port. Data accesses win over
// fetches. The pipeline is stalled (pipe_wen=0) until every pending request
// has a completion flag.
// Optional feature macro: ARB_STALL_CNT_EN enables the saturating stall counter;
// without it stall_cnt is tied to zero and no counter flops exist.
module pipe_mem_arbiter #(
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   input  logic [15:0] ram_rdata,
   output logic        ram_en,
   output logic        ram_wr,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_wdata,
   output logic        if_valid,
   output logic [15:0] if_data,
   output logic        mem_valid,
   output logic [15:0] mem_rdata,
   output logic        pipe_wen,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {IDLE, DATA_BUSY, FETCH_BUSY} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        d_done_q, d_done_d;
   logic        i_done_q, i_done_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] if_data_q, if_data_d;
   logic [15:0] mem_rdata_q, mem_rdata_d;
   logic        d_fin, i_fin;
   logic        mem_req;

   assign mem_req  = mem_read | mem_write;
   assign pipe_wen = (state_q == IDLE) && (!mem_req || d_done_q) && (!if_req || i_done_q);

   // Next-state, access latching and completion-flag logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      d_fin       = 1'b0;
      i_fin       = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_req && !d_done_q) begin
               state_d = DATA_BUSY;
               cnt_d   = CNT_LOAD;
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               wr_d    = mem_write;
            end else if (if_req && !i_done_q) begin
               state_d = FETCH_BUSY;
               cnt_d   = CNT_LOAD;
               addr_d  = if_addr;
               wr_d    = 1'b0;
            end
         end
         DATA_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
               d_fin   = 1'b1;
               // Stores leave the load-data register untouched
               if (!wr_q) mem_rdata_d = ram_rdata;
            end
         end
         FETCH_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d   = IDLE;
               i_fin     = 1'b1;
               if_data_d = ram_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
      // A flag survives only while its request is still held and the pipe is
      // stalled; a dropped request discards its completion.
      d_done_d = !pipe_wen && mem_req && (d_done_q || d_fin);
      i_done_d = !pipe_wen && if_req && (i_done_q || i_fin);
   end

   // State and datapath registers; reset also aborts an in-flight access
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         d_done_q    <= 1'b0;
         i_done_q    <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= 16'd0;
         wdata_q     <= 16'd0;
         if_data_q   <= 16'd0;
         mem_rdata_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         d_done_q    <= d_done_d;
         i_done_q    <= i_done_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign ram_en    = (state_q != IDLE);
   assign ram_wr    = (state_q == DATA_BUSY) && wr_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign if_valid  = i_done_q;
   assign if_data   = if_data_q;
   assign mem_valid = d_done_q;
   assign mem_rdata = mem_rdata_q;

`ifdef ARB_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   // Saturating count of stalled cycles
   always_comb begin
      stall_d = stall_q;
      if (!pipe_wen && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      if (rst) stall_q <= 16'd0;
      else     stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed self-checking bench for pipe_mem_arbiter at LATENCY=2.
// Cycle 0 is the cycle in which a scenario's requests are first applied;
// outputs are sampled 1 time unit after each rising edge.
module tb_pipe_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] ram_rdata;
   logic        ram_en;
   logic        ram_wr;
   logic [15:0] ram_addr;
   logic [15:0] ram_wdata;
   logic        if_valid;
   logic [15:0] if_data;
   logic        mem_valid;
   logic [15:0] mem_rdata;
   logic        pipe_wen;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

`ifdef ARB_STALL_CNT_EN
   localparam logic [15:0] LF_STALLS = 16'd6;
`else
   localparam logic [15:0] LF_STALLS = 16'd0;
`endif

   pipe_mem_arbiter #(.LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .ram_rdata(ram_rdata),
      .ram_en(ram_en), .ram_wr(ram_wr),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .if_valid(if_valid), .if_data(if_data),
      .mem_valid(mem_valid), .mem_rdata(mem_rdata),
      .pipe_wen(pipe_wen), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      if_req    = 1'b0;
      if_addr   = 16'h0000;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 16'h0000;
      mem_wdata = 16'h0000;
      ram_rdata = 16'h0000;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ram_en !== 1'b0)        begin errors++; $display("FAIL reset_ram_en got %h exp 0", ram_en); end
      checks++; if (ram_wr !== 1'b0)        begin errors++; $display("FAIL reset_ram_wr got %h exp 0", ram_wr); end
      checks++; if (ram_addr !== 16'h0)     begin errors++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
      checks++; if (ram_wdata !== 16'h0)    begin errors++; $display("FAIL reset_ram_wdata got %h exp 0", ram_wdata); end
      checks++; if (if_valid !== 1'b0)      begin errors++; $display("FAIL reset_if_valid got %h exp 0", if_valid); end
      checks++; if (mem_valid !== 1'b0)     begin errors++; $display("FAIL reset_mem_valid got %h exp 0", mem_valid); end
      checks++; if (if_data !== 16'h0)      begin errors++; $display("FAIL reset_if_data got %h exp 0", if_data); end
      checks++; if (mem_rdata !== 16'h0)    begin errors++; $display("FAIL reset_mem_rdata got %h exp 0", mem_rdata); end
      checks++; if (pipe_wen !== 1'b1)      begin errors++; $display("FAIL reset_pipe_wen got %h exp 1", pipe_wen); end
      checks++; if (stall_cnt !== 16'h0)    begin errors++; $display("FAIL reset_stall_cnt got %h exp 0", stall_cnt); end
   endtask

   task automatic test_fetch();
      do_reset();
      if_req    = 1'b1;
      if_addr   = 16'h0010;
      ram_rdata = 16'hA5A5;
      #1;
      checks++; if (pipe_wen !== 1'b0) begin errors++; $display("FAIL fetch_c0_pipe_wen got %h exp 0", pipe_wen); end
      for (int cyc = 1; cyc <= 3; cyc++) begin
         step();
         checks++; if (ram_en !== (cyc <= 2)) begin errors++; $display("FAIL fetch_c%0d_ram_en got %h exp %h", cyc, ram_en, (cyc <= 2)); end
         checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL fetch_c%0d_ram_wr got %h exp 0", cyc, ram_wr); end
         checks++; if (if_valid !== (cyc == 3)) begin errors++; $display("FAIL fetch_c%0d_if_valid got %h exp %h", cyc, if_valid, (cyc == 3)); end
         checks++; if (pipe_wen !== (cyc == 3)) begin errors++; $display("FAIL fetch_c%0d_pipe_wen got %h exp %h", cyc, pipe_wen, (cyc == 3)); end
         checks++; if (ram_addr !== 16'h0010) begin errors++; $display("FAIL fetch_c%0d_ram_addr got %h exp 0010", cyc, ram_addr); end
      end
      checks++; if (if_data !== 16'hA5A5) begin errors++; $display("FAIL fetch_if_data got %h exp a5a5", if_data); end
      if_req    = 1'b0;
      ram_rdata = 16'h0F0F;
      step();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_drop_if_valid got %h exp 0", if_valid); end
      checks++; if (if_data !== 16'hA5A5) begin errors++; $display("FAIL fetch_hold_if_data got %h exp a5a5", if_data); end
      checks++; if (pipe_wen !== 1'b1) begin errors++; $display("FAIL fetch_drop_pipe_wen got %h exp 1", pipe_wen); end
   endtask

   task automatic test_load_fetch();
      logic       e_en, e_wen, e_mv, e_iv;
      logic [15:0] e_addr;
      do_reset();
      mem_read  = 1'b1;
      mem_addr  = 16'h0200;
      if_req    = 1'b1;
      if_addr   = 16'h0040;
      ram_rdata = 16'h1111;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         step();
         e_en   = (cyc == 1) || (cyc == 2) || (cyc == 4) || (cyc == 5);
         e_wen  = (cyc == 6);
         e_mv   = (cyc >= 3);
         e_iv   = (cyc == 6);
         e_addr = (cyc <= 3) ? 16'h0200 : 16'h0040;
         checks++; if (ram_en !== e_en) begin errors++; $display("FAIL lf_c%0d_ram_en got %h exp %h", cyc, ram_en, e_en); end
         checks++; if (pipe_wen !== e_wen) begin errors++; $display("FAIL lf_c%0d_pipe_wen got %h exp %h", cyc, pipe_wen, e_wen); end
         checks++; if (mem_valid !== e_mv) begin errors++; $display("FAIL lf_c%0d_mem_valid got %h exp %h", cyc, mem_valid, e_mv); end
         checks++; if (if_valid !== e_iv) begin errors++; $display("FAIL lf_c%0d_if_valid got %h exp %h", cyc, if_valid, e_iv); end
         checks++; if (ram_addr !== e_addr) begin errors++; $display("FAIL lf_c%0d_ram_addr got %h exp %h", cyc, ram_addr, e_addr); end
         if (cyc == 3) ram_rdata = 16'h2222;
      end
      checks++; if (mem_rdata !== 16'h1111) begin errors++; $display("FAIL lf_mem_rdata got %h exp 1111", mem_rdata); end
      checks++; if (if_data !== 16'h2222) begin errors++; $display("FAIL lf_if_data got %h exp 2222", if_data); end
      checks++; if (stall_cnt !== LF_STALLS) begin errors++; $display("FAIL lf_stall_cnt got %0d exp %0d", stall_cnt, LF_STALLS); end
      mem_read = 1'b0;
      if_req   = 1'b0;
      step();
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL lf_c7_mem_valid got %h exp 0", mem_valid); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL lf_c7_if_valid got %h exp 0", if_valid); end
      checks++; if (stall_cnt !== LF_STALLS) begin errors++; $display("FAIL lf_c7_stall_cnt got %0d exp %0d", stall_cnt, LF_STALLS); end
   endtask

   // Runs directly after test_load_fetch so mem_rdata holds 0x1111
   task automatic test_store();
      mem_write = 1'b1;
      mem_addr  = 16'h0300;
      mem_wdata = 16'h1234;
      ram_rdata = 16'hDEAD;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         step();
         checks++; if (ram_wr !== (cyc <= 2)) begin errors++; $display("FAIL st_c%0d_ram_wr got %h exp %h", cyc, ram_wr, (cyc <= 2)); end
         checks++; if (ram_en !== (cyc <= 2)) begin errors++; $display("FAIL st_c%0d_ram_en got %h exp %h", cyc, ram_en, (cyc <= 2)); end
         checks++; if (ram_wdata !== 16'h1234) begin errors++; $display("FAIL st_c%0d_ram_wdata got %h exp 1234", cyc, ram_wdata); end
         checks++; if (ram_addr !== 16'h0300) begin errors++; $display("FAIL st_c%0d_ram_addr got %h exp 0300", cyc, ram_addr); end
         checks++; if (mem_valid !== (cyc == 3)) begin errors++; $display("FAIL st_c%0d_mem_valid got %h exp %h", cyc, mem_valid, (cyc == 3)); end
      end
      checks++; if (mem_rdata !== 16'h1111) begin errors++; $display("FAIL st_mem_rdata got %h exp 1111", mem_rdata); end
      checks++; if (pipe_wen !== 1'b1) begin errors++; $display("FAIL st_pipe_wen got %h exp 1", pipe_wen); end
      mem_write = 1'b0;
      step();
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL st_drop_mem_valid got %h exp 0", mem_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_read = 1'b1;
      mem_addr = 16'h0400;
      step();
      checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL rm_c1_ram_en got %h exp 1", ram_en); end
      rst = 1'b1;
      step();
      rst      = 1'b0;
      mem_read = 1'b0;
      checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rm_ram_en got %h exp 0", ram_en); end
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rm_mem_valid got %h exp 0", mem_valid); end
      checks++; if (ram_addr !== 16'h0) begin errors++; $display("FAIL rm_ram_addr got %h exp 0", ram_addr); end
      step();
      checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rm_after_ram_en got %h exp 0", ram_en); end
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rm_after_mem_valid got %h exp 0", mem_valid); end
   endtask

   task automatic test_idle();
      do_reset();
      for (int cyc = 1; cyc <= 10; cyc++) begin
         step();
         checks++; if (pipe_wen !== 1'b1) begin errors++; $display("FAIL idle_c%0d_pipe_wen got %h exp 1", cyc, pipe_wen); end
         checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL idle_c%0d_ram_en got %h exp 0", cyc, ram_en); end
         checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL idle_c%0d_stall_cnt got %0d exp 0", cyc, stall_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_load_fetch();
      test_store();
      test_reset_mid();
      test_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
